// File: rtl/bpu_pkg.sv
// Shared types and constants for the gshare predictor, its PHT and the pipeline control-flow decode.
package bpu_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t      CTR_WNT    = 2'b01;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bpu_state_e;

  function automatic ctr2_t ctr_sat_update(input ctr2_t ctr, input logic taken);
    ctr2_t res;
    res = ctr;
    if (taken && ctr != 2'b11) res = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) res = ctr - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2-bit counters with async read ports and one sync write port
// shared between the init sweep and saturating training updates.
module bpu_pht
  import bpu_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  output logic [1:0]       up_ctr,
  input  logic             up_en,
  input  logic             up_taken,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_idx
);

  ctr2_t            pht_q [2**IDX_W];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  ctr2_t            wr_data;

  assign rd_ctr = pht_q[rd_idx];
  assign up_ctr = pht_q[up_idx];

  // The sweep owns the write port; the top never asserts up_en while it runs.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = up_idx;
    wr_data = ctr_sat_update(up_ctr, up_taken);
    if (init_en) begin
      wr_en   = 1'b1;
      wr_idx  = init_idx;
      wr_data = CTR_WNT;
    end else if (up_en) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) pht_q[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/gshare_bpu.sv
// Gshare branch predictor top: init FSM, non-speculative GHR, index hash, mispredict flag.
// Optional BPU_STATS_EN adds stat_branches / stat_mispred counters.
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int GHR_W  = 8,
  parameter int PC_LSB = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             lk_valid,
  input  logic [31:0]      lk_pc,
  input  logic [6:0]       lk_opcode,
  output logic             lk_taken,
  output logic [IDX_W-1:0] lk_idx,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_idx,
  input  logic [6:0]       up_opcode,
  input  logic             up_taken,
  output logic             mispredict
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
`endif
);

  bpu_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             mispred_q, mispred_d;
  logic [1:0]       rd_ctr;
  logic [1:0]       up_ctr;
  logic             up_acc;
  logic             unused_pc;

  assign unused_pc = ^{lk_pc[31:PC_LSB+IDX_W], lk_pc[PC_LSB-1:0]};

  assign ready      = (state_q == ST_RUN);
  assign lk_idx     = lk_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr_q);
  assign up_acc     = up_valid & ready & (up_opcode == OPC_BRANCH);
  assign mispredict = mispred_q;

  bpu_pht #(.IDX_W(IDX_W)) u_pht (
    .clk      (clk),
    .rd_idx   (lk_idx),
    .rd_ctr   (rd_ctr),
    .up_idx   (up_idx),
    .up_ctr   (up_ctr),
    .up_en    (up_acc),
    .up_taken (up_taken),
    .init_en  (state_q == ST_INIT),
    .init_idx (sweep_q)
  );

  always_comb begin
    lk_taken = 1'b0;
    if (lk_valid && ready) begin
      case (lk_opcode)
        OPC_JAL, OPC_JALR: lk_taken = 1'b1;
        OPC_BRANCH:        lk_taken = rd_ctr[1];
        default:           lk_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    ghr_d     = ghr_q;
    mispred_d = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (up_acc) begin
          ghr_d     = {ghr_q[GHR_W-2:0], up_taken};
          mispred_d = up_taken ^ up_ctr[1];
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      ghr_q     <= '0;
      mispred_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      ghr_q     <= ghr_d;
      mispred_q <= mispred_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (up_acc) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (up_taken ^ up_ctr[1]) stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_gshare_bpu.sv
// Self-checking bench for gshare_bpu against an integer-counter model of the PHT and GHR.
module tb_gshare_bpu;
  import bpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic [6:0]  lk_opcode;
  logic        lk_taken;
  logic [7:0]  lk_idx;
  logic        up_valid;
  logic [7:0]  up_idx;
  logic [6:0]  up_opcode;
  logic        up_taken;
  logic        mispredict;
`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_pht [256];
  int m_ghr;
  int m_branches;
  int m_mispred;

  always #5 clk = ~clk;

  gshare_bpu #(.IDX_W(8), .GHR_W(8), .PC_LSB(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_opcode  (lk_opcode),
    .lk_taken   (lk_taken),
    .lk_idx     (lk_idx),
    .up_valid   (up_valid),
    .up_idx     (up_idx),
    .up_opcode  (up_opcode),
    .up_taken   (up_taken),
    .mispredict (mispredict)
`ifdef BPU_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int m_index(input logic [31:0] pc);
    return ((int'(pc) >>> 2) & 255) ^ m_ghr;
  endfunction

  function automatic logic m_pred(input logic [31:0] pc, input logic [6:0] opc);
    if (opc == OPC_JAL || opc == OPC_JALR) return 1'b1;
    if (opc == OPC_BRANCH) return (m_pht[m_index(pc)] >= 2);
    return 1'b0;
  endfunction

  // A PC that hashes to idx under the current model GHR, with random ignored bits.
  function automatic logic [31:0] pc_for(input int idx);
    logic [31:0] pc;
    pc = (32'((idx ^ m_ghr) & 255) << 2) | ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 3));
    return pc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_branches = 0;
    m_mispred = 0;
  endtask

  task automatic model_update(input int idx, input logic [6:0] opc, input logic taken);
    if (opc == OPC_BRANCH) begin
      m_branches++;
      if (taken != (m_pht[idx] >= 2)) m_mispred++;
      if (taken && m_pht[idx] < 3) m_pht[idx]++;
      else if (!taken && m_pht[idx] > 0) m_pht[idx]--;
      m_ghr = ((m_ghr << 1) | int'(taken)) & 255;
    end
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic drive_update(input int idx, input logic [6:0] opc, input logic taken,
                              output logic mp_obs, output logic mp_exp);
    @(negedge clk);
    up_valid  = 1'b1;
    up_idx    = idx[7:0];
    up_opcode = opc;
    up_taken  = taken;
    mp_exp    = (opc == OPC_BRANCH) && (taken != (m_pht[idx] >= 2));
    @(negedge clk);
    up_valid = 1'b0;
    mp_obs   = mispredict;
    model_update(idx, opc, taken);
  endtask

  task automatic drive_lookup(input logic [31:0] pc, input logic [6:0] opc,
                              output logic [7:0] idx_obs, output logic tk_obs);
    @(negedge clk);
    lk_valid  = 1'b1;
    lk_pc     = pc;
    lk_opcode = opc;
    #1;
    idx_obs  = lk_idx;
    tk_obs   = lk_taken;
    lk_valid = 1'b0;
  endtask

  task automatic do_reset(output int low_cycles);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    low_cycles = 0;
    while (!ready && low_cycles < 1000) begin
      @(negedge clk);
      low_cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    logic [7:0] io;
    logic tk;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n_checks++;
    if (ready !== 1'b0 || mispredict !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ready=%b mispredict=%b expected 0 0", ready, mispredict);
    end
    cyc = 0;
    while (!ready && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 256) begin
      n_errors++;
      $display("FAIL reset_sweep_len: got %0d cycles expected 256", cyc);
    end
    for (int i = 0; i < 8; i++) begin
      drive_lookup($urandom, OPC_BRANCH, io, tk);
      n_checks++;
      if (tk !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_lookup: got %b expected 0", tk);
      end
    end
  endtask

  task automatic test_training();
    int cyc;
    logic mp, mpe, tk;
    logic [7:0] io;
    do_reset(cyc);
    drive_update(16, OPC_BRANCH, 1'b1, mp, mpe);
    n_checks++;
    if (mp !== 1'b1) begin
      n_errors++;
      $display("FAIL train_mp1: got %b expected 1", mp);
    end
    drive_update(16, OPC_BRANCH, 1'b1, mp, mpe);
    n_checks++;
    if (mp !== 1'b0) begin
      n_errors++;
      $display("FAIL train_mp2: got %b expected 0", mp);
    end
    for (int i = 0; i < 8; i++) begin
      drive_update(0, OPC_BRANCH, 1'b0, mp, mpe);
      n_checks++;
      if (mp !== mpe) begin
        n_errors++;
        $display("FAIL train_clear_mp: got %b expected %b", mp, mpe);
      end
    end
    drive_lookup(32'h40, OPC_BRANCH, io, tk);
    n_checks++;
    if (io !== 8'h10 || tk !== 1'b1) begin
      n_errors++;
      $display("FAIL train_pred: got idx=%h taken=%b expected idx=10 taken=1", io, tk);
    end
  endtask

  task automatic test_history_hash();
    logic mp, mpe, tk;
    logic [7:0] io;
    for (int i = 0; i < 3; i++) begin
      drive_update(128, OPC_BRANCH, (i != 1), mp, mpe);
      n_checks++;
      if (mp !== mpe) begin
        n_errors++;
        $display("FAIL hash_mp: got %b expected %b", mp, mpe);
      end
    end
    drive_lookup(32'h40, OPC_BRANCH, io, tk);
    n_checks++;
    if (io !== 8'h15 || tk !== m_pred(32'h40, OPC_BRANCH)) begin
      n_errors++;
      $display("FAIL hash_idx: got idx=%h taken=%b expected idx=15 taken=%b",
               io, tk, m_pred(32'h40, OPC_BRANCH));
    end
  endtask

  task automatic test_saturation();
    logic mp, mpe, tk;
    logic [7:0] io;
    logic [31:0] pc;
    for (int i = 0; i < 5; i++) drive_update(51, OPC_BRANCH, 1'b1, mp, mpe);
    drive_update(51, OPC_BRANCH, 1'b0, mp, mpe);
    n_checks++;
    if (mp !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_hi_mp: got %b expected 1", mp);
    end
    pc = pc_for(51);
    drive_lookup(pc, OPC_BRANCH, io, tk);
    n_checks++;
    if (tk !== 1'b1 || io !== 8'd51) begin
      n_errors++;
      $display("FAIL sat_hi_pred: got idx=%h taken=%b expected idx=33 taken=1", io, tk);
    end
    for (int i = 0; i < 3; i++) drive_update(68, OPC_BRANCH, 1'b0, mp, mpe);
    drive_update(68, OPC_BRANCH, 1'b1, mp, mpe);
    pc = pc_for(68);
    drive_lookup(pc, OPC_BRANCH, io, tk);
    n_checks++;
    if (tk !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_lo_pred: got %b expected 0", tk);
    end
    drive_update(68, OPC_BRANCH, 1'b1, mp, mpe);
    pc = pc_for(68);
    drive_lookup(pc, OPC_BRANCH, io, tk);
    n_checks++;
    if (tk !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_lo_recover: got %b expected 1", tk);
    end
  endtask

  task automatic test_jal_jalr();
    logic mp, mpe, tk;
    logic [7:0] io;
    logic [31:0] pc;
    for (int i = 0; i < 3; i++) begin
      drive_update(144, (i == 1) ? OPC_JALR : OPC_JAL, 1'b1, mp, mpe);
      n_checks++;
      if (mp !== 1'b0) begin
        n_errors++;
        $display("FAIL jal_mp: got %b expected 0", mp);
      end
    end
    pc = pc_for(144);
    drive_lookup(pc, OPC_BRANCH, io, tk);
    n_checks++;
    if (io !== 8'd144 || tk !== m_pred(pc, OPC_BRANCH)) begin
      n_errors++;
      $display("FAIL jal_no_train: got idx=%h taken=%b expected idx=90 taken=%b",
               io, tk, m_pred(pc, OPC_BRANCH));
    end
    drive_lookup($urandom, OPC_JAL, io, tk);
    n_checks++;
    if (tk !== 1'b1) begin
      n_errors++;
      $display("FAIL jal_lookup: got %b expected 1", tk);
    end
    drive_lookup($urandom, OPC_JALR, io, tk);
    n_checks++;
    if (tk !== 1'b1) begin
      n_errors++;
      $display("FAIL jalr_lookup: got %b expected 1", tk);
    end
    drive_lookup($urandom, 7'b0110011, io, tk);
    n_checks++;
    if (tk !== 1'b0) begin
      n_errors++;
      $display("FAIL other_lookup: got %b expected 0", tk);
    end
  endtask

  task automatic test_collision();
    int cyc;
    do_reset(cyc);
    @(negedge clk);
    lk_valid  = 1'b1;
    lk_pc     = pc_for(32);
    lk_opcode = OPC_BRANCH;
    up_valid  = 1'b1;
    up_idx    = 8'd32;
    up_opcode = OPC_BRANCH;
    up_taken  = 1'b1;
    #1;
    n_checks++;
    if (lk_taken !== 1'b0 || lk_idx !== 8'd32) begin
      n_errors++;
      $display("FAIL collide_same: got idx=%h taken=%b expected idx=20 taken=0", lk_idx, lk_taken);
    end
    @(negedge clk);
    up_valid = 1'b0;
    model_update(32, OPC_BRANCH, 1'b1);
    lk_pc = pc_for(32);
    #1;
    n_checks++;
    if (lk_taken !== 1'b1 || lk_idx !== 8'd32 || mispredict !== 1'b1) begin
      n_errors++;
      $display("FAIL collide_next: got idx=%h taken=%b mp=%b expected idx=20 taken=1 mp=1",
               lk_idx, lk_taken, mispredict);
    end
    lk_valid = 1'b0;
  endtask

  task automatic test_midsweep_reset();
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 100; c++) begin
      if (c == 10) begin
        lk_valid  = 1'b1;
        lk_pc     = $urandom;
        lk_opcode = OPC_JAL;
        up_valid  = 1'b1;
        up_idx    = 8'd5;
        up_opcode = OPC_BRANCH;
        up_taken  = 1'b1;
        #1;
        n_checks++;
        if (lk_taken !== 1'b0) begin
          n_errors++;
          $display("FAIL sweep_lookup: got %b expected 0", lk_taken);
        end
      end
      if (c == 11) begin
        lk_valid = 1'b0;
        up_valid = 1'b0;
        n_checks++;
        if (mispredict !== 1'b0) begin
          n_errors++;
          $display("FAIL sweep_drop_mp: got %b expected 0", mispredict);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++;
      $display("FAIL sweep_mid_ready: got %b expected 0", ready);
    end
    do_reset(cyc);
    n_checks++;
    if (cyc != 256) begin
      n_errors++;
      $display("FAIL midsweep_len: got %0d cycles expected 256", cyc);
    end
  endtask

  task automatic test_random();
    logic mp, mpe, tk, tke;
    logic [7:0] io;
    logic [31:0] pc;
    logic [6:0] opc;
    int idx, ie;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       opc = OPC_JAL;
        1:       opc = OPC_JALR;
        2:       opc = 7'($urandom);
        default: opc = OPC_BRANCH;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        idx = $urandom_range(0, 15) * 16 + 3;
        drive_update(idx, opc, 1'($urandom), mp, mpe);
        n_checks++;
        if (mp !== mpe) begin
          n_errors++;
          $display("FAIL rand_mp: idx=%0d got %b expected %b", idx, mp, mpe);
        end
      end else begin
        pc  = pc_for($urandom_range(0, 15) * 16 + 3);
        ie  = m_index(pc);
        tke = m_pred(pc, opc);
        drive_lookup(pc, opc, io, tk);
        n_checks++;
        if (io !== ie[7:0] || tk !== tke) begin
          n_errors++;
          $display("FAIL rand_lookup: got idx=%h taken=%b expected idx=%h taken=%b",
                   io, tk, ie[7:0], tke);
        end
      end
    end
`ifdef BPU_STATS_EN
    n_checks++;
    if (stat_branches !== 32'(m_branches) || stat_mispred !== 32'(m_mispred)) begin
      n_errors++;
      $display("FAIL stats: got %0d/%0d expected %0d/%0d",
               stat_branches, stat_mispred, m_branches, m_mispred);
    end
`endif
  endtask

  initial begin
    rst       = 1'b0;
    lk_valid  = 1'b0;
    lk_pc     = '0;
    lk_opcode = '0;
    up_valid  = 1'b0;
    up_idx    = '0;
    up_opcode = '0;
    up_taken  = 1'b0;
    model_reset();
    test_reset();
    test_training();
    test_history_hash();
    test_saturation();
    test_jal_jalr();
    test_collision();
    test_midsweep_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
